// File: rtl/serial_pkg.sv
// Shared definitions for the serial PISO transmitter.
// Contents:
//   state_t     - transmitter FSM states (IDLE, SHIFT)
//   nbits()     - frame length in bits (data bits plus optional parity bit)
//   even_parity - even-parity bit of a word (the word is zero-extended to 64 bits)
//   CNT_W_DEFAULT - bit-counter width for the default 8-bit, no-parity frame
package serial_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int nbits(input int width, input int parity);
    return width + parity;
  endfunction

  // Zero extension does not change the XOR reduction, so any WIDTH up to
  // 64 bits can be passed in.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

  localparam int CNT_W_DEFAULT = $clog2(nbits(8, 0));

endpackage

// File: rtl/piso_shift_reg.sv
// N-bit enabled shift register with parallel load, used as the PISO datapath.
// Ports:
//   i_clk    - rising-edge clock
//   i_rst_n  - asynchronous active-low reset (clears the register)
//   i_en     - clock enable; when 0 the register holds
//   i_load   - load i_d (highest priority)
//   i_shift  - shift left by one with zero fill
//   i_clear  - clear to zero
//   i_d      - parallel load word
//   o_q      - register contents
module piso_shift_reg #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic         i_clear,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  // Enabled D-flip-flop bank: load, shift or clear only on enabled edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= {N{1'b0}};
    end else if (i_en) begin
      if (i_load) begin
        r_q <= i_d;
      end else if (i_shift) begin
        r_q <= {r_q[N-2:0], 1'b0};
      end else if (i_clear) begin
        r_q <= {N{1'b0}};
      end else begin
        r_q <= r_q;
      end
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in/serial-out transmitter. It accepts a WIDTH-bit word over a
// valid/ready handshake and sends it MSB first, one bit per enabled clock
// edge. When PARITY=1, an even-parity bit follows the data bits.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   En         - clock enable; all state holds while low
//   load_valid - producer offers load_data
//   load_data  - word to transmit
//   load_ready - a word can be accepted this cycle
//   sout       - serial data bit (MSB of the shift register)
//   sout_valid - sout carries a frame bit
//   last       - final bit of the frame is on sout
//   busy       - transmitter is in SHIFT
module serial_tx_piso
  import serial_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int NBITS = nbits(WIDTH, PARITY);
  localparam int CNT_W = $clog2(NBITS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NBITS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [NBITS-1:0] w_load_word;
  logic [NBITS-1:0] w_shreg;
  logic             w_xfer;
  logic             w_last;
  logic             w_sr_load;
  logic             w_sr_shift;
  logic             w_sr_clear;

  generate
    if (PARITY != 0) begin : g_par
      assign w_load_word = {load_data, even_parity(64'(load_data))};
    end else begin : g_nopar
      assign w_load_word = load_data;
    end
  endgenerate

  // The last bit slot doubles as an accept slot, so back-to-back frames
  // leave no idle gap.
  assign w_last     = (r_state == SHIFT) && (r_cnt == CNT_ZERO);
  assign load_ready = reset && En && ((r_state == IDLE) || w_last);
  assign w_xfer     = load_valid && load_ready;

  // Next-state and datapath control for the frame sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_load   = 1'b0;
    w_sr_shift  = 1'b0;
    w_sr_clear  = 1'b0;
    if (w_xfer) begin
      w_state_nxt = SHIFT;
      w_cnt_nxt   = CNT_LOAD;
      w_sr_load   = 1'b1;
    end else if (En && (r_state == SHIFT)) begin
      if (r_cnt != CNT_ZERO) begin
        w_cnt_nxt  = r_cnt - CNT_ONE;
        w_sr_shift = 1'b1;
      end else begin
        w_state_nxt = IDLE;
        w_sr_clear  = 1'b1;
      end
    end else begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
    end
  end

  // FSM state and bit counter, advancing only on enabled edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= CNT_ZERO;
    end else if (En) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end else begin
      r_state <= r_state;
      r_cnt   <= r_cnt;
    end
  end

  piso_shift_reg #(
    .N (NBITS)
  ) u_shreg (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_en    (En),
    .i_load  (w_sr_load),
    .i_shift (w_sr_shift),
    .i_clear (w_sr_clear),
    .i_d     (w_load_word),
    .o_q     (w_shreg)
  );

  assign sout       = w_shreg[NBITS-1];
  assign busy       = (r_state == SHIFT);
  assign sout_valid = busy;
  assign last       = w_last;

endmodule

// File: tb/tb_serial_tx_piso.sv
// Bench for serial_tx_piso. Two instances run side by side: u_dut0
// (WIDTH=8, PARITY=0) and u_dut1 (WIDTH=8, PARITY=1). A frame-level model
// holds the bit list of each instance's current frame and a position within
// it. The bench compares every output of both instances each cycle and also
// compares directed captures of whole frames.
module tb_serial_tx_piso;

  logic       clk = 1'b0;
  logic       reset;
  logic       En;
  logic       lv0, lv1;
  logic [7:0] ld0, ld1;
  logic       rdy0, sout0, sv0, last0, busy0;
  logic       rdy1, sout1, sv1, last1, busy1;

  int n_cmp = 0;
  int n_mis = 0;

  // Frame-level reference model, one entry per instance.
  int nb[2] = '{8, 9};
  bit fb[2][9];
  int pos[2];
  bit act[2];

  logic [15:0] cap;

  always #5 clk = ~clk;

  serial_tx_piso #(.WIDTH(8), .PARITY(0)) u_dut0 (
    .clk(clk), .reset(reset), .En(En), .load_valid(lv0), .load_data(ld0),
    .load_ready(rdy0), .sout(sout0), .sout_valid(sv0), .last(last0), .busy(busy0));

  serial_tx_piso #(.WIDTH(8), .PARITY(1)) u_dut1 (
    .clk(clk), .reset(reset), .En(En), .load_valid(lv1), .load_data(ld1),
    .load_ready(rdy1), .sout(sout1), .sout_valid(sv1), .last(last1), .busy(busy1));

  function automatic bit m_ready(input int i);
    return (reset === 1'b1) && (En === 1'b1) && (!act[i] || (pos[i] == nb[i] - 1));
  endfunction

  function automatic bit m_sout(input int i);
    return act[i] ? fb[i][pos[i]] : 1'b0;
  endfunction

  function automatic bit m_last(input int i);
    return act[i] && (pos[i] == nb[i] - 1);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0;
      pos[i] = 0;
    end
  endtask

  task automatic m_adv(input int i, input bit x, input logic [7:0] w);
    if (x) begin
      for (int k = 0; k < 8; k++) fb[i][k] = w[7-k];
      if (nb[i] == 9) fb[i][8] = ^w;
      pos[i] = 0;
      act[i] = 1'b1;
    end else if (act[i]) begin
      if (pos[i] == nb[i] - 1) act[i] = 1'b0;
      else pos[i] = pos[i] + 1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d0_sout",  sout0, m_sout(0));
    chk("d0_valid", sv0,   act[0]);
    chk("d0_busy",  busy0, act[0]);
    chk("d0_last",  last0, m_last(0));
    chk("d0_ready", rdy0,  m_ready(0));
    chk("d1_sout",  sout1, m_sout(1));
    chk("d1_valid", sv1,   act[1]);
    chk("d1_busy",  busy1, act[1]);
    chk("d1_last",  last1, m_last(1));
    chk("d1_ready", rdy1,  m_ready(1));
  endtask

  // One clock: predict transfers from the pre-edge inputs, then check #1 after the edge.
  task automatic tick();
    bit x0, x1;
    x0 = lv0 && m_ready(0);
    x1 = lv1 && m_ready(1);
    @(posedge clk);
    if (reset === 1'b1 && En === 1'b1) begin
      m_adv(0, x0, ld0);
      m_adv(1, x1, ld1);
    end
    #1;
    check_all();
  endtask

  task automatic drain();
    lv0 = 1'b0;
    lv1 = 1'b0;
    En  = 1'b1;
    for (int i = 0; i < 11; i++) tick();
  endtask

  initial begin
    reset = 1'b0; En = 1'b1;
    lv0 = 1'b0; lv1 = 1'b0; ld0 = 8'h00; ld1 = 8'h00;
    m_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single frame of A5 on the no-parity instance.
    lv0 = 1'b1; ld0 = 8'hA5;
    tick();
    lv0 = 1'b0; ld0 = 8'h00;
    cap = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      cap = {cap[14:0], sout0};
      if (k < 7) tick();
    end
    chk_w("t1_frame", cap, 16'h00A5);
    tick();
    chk("t1_idle_sout", sout0, 1'b0);
    chk("t1_idle_ready", rdy0, 1'b1);

    // Parity frames on the parity instance.
    lv1 = 1'b1; ld1 = 8'h07;
    tick();
    lv1 = 1'b0;
    cap = 16'h0000;
    for (int k = 0; k < 9; k++) begin
      cap = {cap[14:0], sout1};
      if (k == 8) chk("t2_last9", last1, 1'b1);
      if (k < 8) tick();
    end
    chk_w("t2_frame07", cap, 16'h000F);
    lv1 = 1'b1; ld1 = 8'h03;
    tick();
    lv1 = 1'b0;
    cap = 16'h0000;
    for (int k = 0; k < 9; k++) begin
      cap = {cap[14:0], sout1};
      if (k < 8) tick();
    end
    chk_w("t2_frame03", cap, 16'h0006);
    drain();

    // Back-to-back frames with load_valid held.
    lv0 = 1'b1; ld0 = 8'hA5;
    tick();
    ld0 = 8'h3C;
    cap = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      cap = {cap[14:0], sout0};
      chk("t3_valid", sv0, 1'b1);
      if (k < 15) tick();
      if (k == 7) lv0 = 1'b0;
    end
    chk_w("t3_b2b", cap, 16'hA53C);
    drain();

    // Clock-enable stall after bit 3.
    lv0 = 1'b1; ld0 = 8'hA5;
    tick();
    lv0 = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    En = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_hold_sout", sout0, 1'b0);
      chk("t4_hold_ready", rdy0, 1'b0);
    end
    En = 1'b1;
    tick();
    chk("t4_resume_bit4", sout0, 1'b0);
    tick();
    chk("t4_resume_bit5", sout0, 1'b1);
    drain();

    // Asynchronous reset in mid-frame.
    lv0 = 1'b1; ld0 = 8'hA5;
    tick();
    lv0 = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    check_all();
    chk("t5_busy_now", busy0, 1'b0);
    tick();
    reset = 1'b1;
    lv0 = 1'b1; ld0 = 8'hFF;
    tick();
    lv0 = 1'b0;
    cap = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      cap = {cap[14:0], sout0};
      if (k < 7) tick();
    end
    chk_w("t5_ff", cap, 16'h00FF);
    drain();

    // load_valid waiting for En after reset release.
    reset = 1'b0; En = 1'b0;
    #1;
    m_reset();
    lv0 = 1'b1; ld0 = 8'h5A;
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    chk("t6_no_xfer", busy0, 1'b0);
    En = 1'b1;
    tick();
    chk("t6_xfer", busy0, 1'b1);
    chk("t6_msb", sout0, 1'b0);
    drain();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      En  = ($urandom_range(0, 7) != 0);
      lv0 = $urandom_range(0, 1) == 1;
      lv1 = $urandom_range(0, 1) == 1;
      ld0 = 8'($urandom);
      ld1 = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        #1;
        m_reset();
        check_all();
        reset = 1'b1;
      end
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
